// File: rtl/vdg_timing_pkg.sv
// Shared timing definitions for the VDG raster sequencer: phase encoding,
// default raster geometry, derived boundaries and the registered strobe bundle.
package vdg_timing_pkg;

  typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;

  localparam int DEF_H_ACTIVE      = 256;
  localparam int DEF_H_FP          = 24;
  localparam int DEF_H_SYNC        = 24;
  localparam int DEF_H_BP          = 16;
  localparam int DEF_V_ACTIVE      = 192;
  localparam int DEF_V_FP          = 25;
  localparam int DEF_V_SYNC        = 3;
  localparam int DEF_V_BP          = 42;
  localparam int DEF_LINES_PER_ROW = 12;

  localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  // Registered strobes presented alongside hcount/vcount
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic de;
    logic frame_start;
    logic cnt_en;
    logic cnt_clr;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0,
                                        frame_start: 1'b0, cnt_en: 1'b0, cnt_clr: 1'b1};

endpackage

// File: rtl/scan_axis_counter.sv
// One raster axis: position counter plus ACT/FP/SYNC/BP phase FSM.
// 'phase' is the phase the axis enters on the coming edge, so the parent can
// register strobes that line up with the count it will present.
module scan_axis_counter
  import vdg_timing_pkg::*;
#(
  parameter int W        = 9,
  parameter int ACT_LEN  = DEF_H_ACTIVE,
  parameter int FP_LEN   = DEF_H_FP,
  parameter int SYNC_LEN = DEF_H_SYNC,
  parameter int BP_LEN   = DEF_H_BP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         clear,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap
);

  localparam int TOTAL = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN;
  localparam logic [W-1:0] ACT_END  = W'(ACT_LEN - 1);
  localparam logic [W-1:0] FP_END   = W'(ACT_LEN + FP_LEN - 1);
  localparam logic [W-1:0] SYNC_END = W'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);

  if (ACT_LEN < 1 || FP_LEN < 1 || SYNC_LEN < 1 || BP_LEN < 1) begin : g_bad_len
    $error("scan_axis_counter: every phase length must be at least 1");
  end
  if (TOTAL > (2 ** W)) begin : g_bad_width
    $error("scan_axis_counter: axis total does not fit in W bits");
  end

  phase_t       state, state_nxt;
  logic [W-1:0] count_nxt;

  // Next position and phase: clear returns to the origin, step advances/wraps
  always_comb begin
    count_nxt = count;
    state_nxt = state;
    wrap      = 1'b0;
    if (clear) begin
      count_nxt = '0;
      state_nxt = ACT;
    end else if (step) begin
      wrap      = (count == LAST);
      count_nxt = wrap ? '0 : count + 1'b1;
      case (state)
        ACT:     if (count == ACT_END)  state_nxt = FP;
        FP:      if (count == FP_END)   state_nxt = SYNC;
        SYNC:    if (count == SYNC_END) state_nxt = BP;
        BP:      if (wrap)              state_nxt = ACT;
        default: state_nxt = ACT;
      endcase
    end
  end

  assign phase = state_nxt;

  // Position and phase registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      state <= ACT;
    end else begin
      count <= count_nxt;
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/vdg_scan_sequencer.sv
// Raster timing controller for the prototype VDG. Runs the horizontal and
// vertical axes, produces sync/de/frame strobes and the character-row scan
// line, and drives enable/clear of the external dual-edge address counter.
module vdg_scan_sequencer
  import vdg_timing_pkg::*;
#(
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int H_FP          = DEF_H_FP,
  parameter int H_SYNC        = DEF_H_SYNC,
  parameter int H_BP          = DEF_H_BP,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int V_FP          = DEF_V_FP,
  parameter int V_SYNC        = DEF_V_SYNC,
  parameter int V_BP          = DEF_V_BP,
  parameter int LINES_PER_ROW = DEF_LINES_PER_ROW,
  parameter int HW            = 9,
  parameter int VW            = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          de,
  output logic [3:0]    row_line,
  output logic          frame_start,
  output logic          cnt_en,
  output logic          cnt_clr
);

  if (LINES_PER_ROW < 1 || LINES_PER_ROW > 16) begin : g_bad_rows
    $error("vdg_scan_sequencer: LINES_PER_ROW must be 1..16");
  end

  localparam logic [3:0] LAST_ROW = 4'(LINES_PER_ROW - 1);

  logic     active;
  logic     idle, h_step, h_wrap, v_wrap;
  phase_t   h_ph, v_ph;
  strobes_t st, st_nxt;
  logic [3:0] row_nxt;

  // Position only moves once started; the start clock itself holds (0,0)
  assign idle   = ~run;
  assign h_step = active & run;

  scan_axis_counter #(
    .W(HW), .ACT_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP)
  ) u_h (
    .clk(clk), .reset(reset), .step(h_step), .clear(idle),
    .count(hcount), .phase(h_ph), .wrap(h_wrap)
  );

  scan_axis_counter #(
    .W(VW), .ACT_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP)
  ) u_v (
    .clk(clk), .reset(reset), .step(h_wrap), .clear(idle),
    .count(vcount), .phase(v_ph), .wrap(v_wrap)
  );

  // Decode strobes and scan line for the position being entered
  always_comb begin
    st_nxt  = STROBES_IDLE;
    row_nxt = '0;
    if (run) begin
      st_nxt.de          = (h_ph == ACT) && (v_ph == ACT);
      st_nxt.cnt_en      = st_nxt.de;
      st_nxt.hsync_n     = (h_ph != SYNC);
      st_nxt.vsync_n     = (v_ph != SYNC);
      st_nxt.cnt_clr     = (v_ph == SYNC);
      // (0,0) is entered either from idle or by the frame wrap
      st_nxt.frame_start = ~active | v_wrap;
      if (v_ph == ACT && !st_nxt.frame_start)
        row_nxt = h_wrap ? ((row_line == LAST_ROW) ? 4'd0 : row_line + 4'd1) : row_line;
    end
  end

  // Run flag, strobe and scan-line registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      st       <= STROBES_IDLE;
      row_line <= '0;
    end else begin
      active   <= run;
      st       <= st_nxt;
      row_line <= row_nxt;
    end
  end

  assign hsync_n     = st.hsync_n;
  assign vsync_n     = st.vsync_n;
  assign de          = st.de;
  assign frame_start = st.frame_start;
  assign cnt_en      = st.cnt_en;
  assign cnt_clr     = st.cnt_clr;

endmodule

// File: tb/tb_vdg_scan_sequencer.sv
// Scoreboard bench for vdg_scan_sequencer. Full-width horizontal timing,
// shortened vertical timing so several frames fit in a short run.
module tb_vdg_scan_sequencer;

  localparam int HA = 256, HF = 24, HS = 24, HB = 16;
  localparam int VA = 48,  VF = 5,  VS = 3,  VB = 6;
  localparam int LPR = 12;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk = 1'b0, reset = 1'b0, run = 1'b0;
  logic [8:0] hcount, vcount;
  logic [3:0] row_line;
  logic       hsync_n, vsync_n, de, frame_start, cnt_en, cnt_clr;

  vdg_scan_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LINES_PER_ROW(LPR), .HW(9), .VW(9)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .hcount(hcount), .vcount(vcount),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .row_line(row_line),
    .frame_start(frame_start), .cnt_en(cnt_en), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, v, row;
    bit hs_n, vs_n, de, fs, en, clr;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  event async_chk;

  // Reference state: running flag and raster position
  bit mact = 1'b0;
  int mx = 0, my = 0;

  function automatic exp_t expect_now();
    exp_t e;
    e = '{h: 0, v: 0, row: 0, hs_n: 1'b1, vs_n: 1'b1, de: 1'b0, fs: 1'b0, en: 1'b0, clr: 1'b1};
    if (mact) begin
      e.h    = mx;
      e.v    = my;
      e.hs_n = !(mx >= HA + HF && mx < HA + HF + HS);
      e.vs_n = !(my >= VA + VF && my < VA + VF + VS);
      e.de   = (mx < HA) && (my < VA);
      e.en   = e.de;
      e.clr  = !e.vs_n;
      e.fs   = (mx == 0) && (my == 0);
      e.row  = (my < VA) ? (my % LPR) : 0;
    end
    return e;
  endfunction

  // Model update on every clock edge
  initial forever begin
    @(posedge clk);
    if (reset || !run) begin
      mact = 1'b0; mx = 0; my = 0;
    end else if (!mact) begin
      mact = 1'b1;
    end else begin
      mx++;
      if (mx == HT) begin
        mx = 0;
        my++;
        if (my == VT) my = 0;
      end
    end
    q.push_back(expect_now());
  end

  // Model update on asynchronous reset; checked without waiting for a clock
  initial forever begin
    @(posedge reset);
    mact = 1'b0; mx = 0; my = 0;
    q.push_back(expect_now());
    ->async_chk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d (model pos %0d,%0d)", name, $time, act, req, mx, my);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations
  initial forever begin
    exp_t e;
    @(negedge clk or async_chk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("hcount",      32'(hcount),      32'(e.h));
      chk("vcount",      32'(vcount),      32'(e.v));
      chk("row_line",    32'(row_line),    32'(e.row));
      chk("hsync_n",     32'(hsync_n),     32'(e.hs_n));
      chk("vsync_n",     32'(vsync_n),     32'(e.vs_n));
      chk("de",          32'(de),          32'(e.de));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("cnt_en",      32'(cnt_en),      32'(e.en));
      chk("cnt_clr",     32'(cnt_clr),     32'(e.clr));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic run_to(input int x, input int y, input int budget);
    int n = 0;
    while (!(mact && mx == x && my == y)) begin
      if (n == budget) begin
        errors++;
        $display("FAIL run_to: position %0d,%0d not reached within %0d clocks, at %0d,%0d", x, y, budget, mx, my);
        break;
      end
      cycles(1);
      n++;
    end
    checks++;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
  endtask

  initial begin
    // Reset at time 1 with no clock edge
    #1 reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(2);

    // Start and run to mid-frame, then drop run for one clock and restart
    run = 1'b1;
    run_to(100, 30, 2 * HT * VT);
    run = 1'b0;
    cycles(1);
    run = 1'b1;
    cycles(3);

    // One uninterrupted frame, then on into the next frame's vertical sync
    cycles(HT * VT);
    run_to(HA + HF + 5, VA + VF + 1, 2 * HT * VT);

    // Async reset mid-H_SYNC/V_SYNC with run held high
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(HT + 40);

    // Random run toggles with occasional async reset pulses
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 4) reset_pulse();
      run = ($urandom_range(0, 99) < 96);
      cycles(1);
    end
    run = 1'b1;
    cycles(HT * 2);

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
